// File: rtl/line_sequencer.sv
// line_sequencer: maps a line number to a word range and streams its characters, two per word.
// Define LINE_SEQ_CRLF_EN to append a CR/LF terminator to every line.
module line_sequencer #(
   parameter logic [9:0] LEN_MAX = 10'd64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  line,
   output logic        busy,
   output logic        done,
   output logic [7:0]  map_line,
   input  logic [19:0] map_ptr,
   output logic [9:0]  mem_addr,
   input  logic [15:0] mem_dout,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_MAP     = 4'd1,
      S_MAPW    = 4'd2,
      S_FETCH   = 4'd3,
      S_FETCHW  = 4'd4,
      S_EMIT_HI = 4'd5,
      S_EMIT_LO = 4'd6,
      S_TERM    = 4'd7,
      S_DONE    = 4'd8
   } state_t;

`ifdef LINE_SEQ_CRLF_EN
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;
`endif

   state_t      state_q;
   logic        busy_q;
   logic        done_q;
   logic [7:0]  map_line_q;
   logic [9:0]  mem_addr_q;
   logic [7:0]  char_out_q;
   logic        char_valid_q;
   logic [9:0]  count_q;
   logic [9:0]  addr_q;
   logic [15:0] word_q;
`ifdef LINE_SEQ_CRLF_EN
   logic        lf_q;
`endif

   logic        accept_s;
   logic [9:0]  map_cnt_s;
   logic [9:0]  count_dec_s;
   logic [9:0]  addr_inc_s;

   // Handshake qualifier, clamped mapper length and word-step arithmetic
   always_comb begin
      accept_s    = char_valid_q & char_ready;
      count_dec_s = count_q - 10'd1;
      addr_inc_s  = addr_q + 10'd1;
      if (map_ptr[19:10] > LEN_MAX) begin
         map_cnt_s = LEN_MAX;
      end else begin
         map_cnt_s = map_ptr[19:10];
      end
   end

   // Sequencing FSM; every output is a register updated here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         map_line_q   <= 8'h00;
         mem_addr_q   <= 10'h000;
         char_out_q   <= 8'h00;
         char_valid_q <= 1'b0;
         count_q      <= 10'd0;
         addr_q       <= 10'h000;
         word_q       <= 16'h0000;
`ifdef LINE_SEQ_CRLF_EN
         lf_q         <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  map_line_q <= line;
                  busy_q     <= 1'b1;
                  state_q    <= S_MAP;
               end
            end
            S_MAP: begin
               state_q <= S_MAPW;
            end
            S_MAPW: begin
               count_q    <= map_cnt_s;
               addr_q     <= map_ptr[9:0];
               mem_addr_q <= map_ptr[9:0];
               if (map_cnt_s == 10'd0) begin
`ifdef LINE_SEQ_CRLF_EN
                  char_out_q   <= CHAR_CR;
                  char_valid_q <= 1'b1;
                  lf_q         <= 1'b0;
`endif
                  state_q <= S_TERM;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               state_q <= S_FETCHW;
            end
            S_FETCHW: begin
               word_q       <= mem_dout;
               char_out_q   <= mem_dout[15:8];
               char_valid_q <= 1'b1;
               state_q      <= S_EMIT_HI;
            end
            S_EMIT_HI: begin
               if (accept_s) begin
                  char_out_q <= word_q[7:0];
                  state_q    <= S_EMIT_LO;
               end else begin
                  char_out_q <= word_q[15:8];
               end
            end
            S_EMIT_LO: begin
               if (accept_s) begin
                  count_q <= count_dec_s;
                  addr_q  <= addr_inc_s;
                  if (count_dec_s != 10'd0) begin
                     mem_addr_q   <= addr_inc_s;
                     char_valid_q <= 1'b0;
                     state_q      <= S_FETCH;
                  end else begin
`ifdef LINE_SEQ_CRLF_EN
                     char_out_q   <= CHAR_CR;
                     char_valid_q <= 1'b1;
                     lf_q         <= 1'b0;
`else
                     char_valid_q <= 1'b0;
`endif
                     state_q <= S_TERM;
                  end
               end
            end
            S_TERM: begin
`ifdef LINE_SEQ_CRLF_EN
               if (accept_s) begin
                  if (lf_q) begin
                     char_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                     busy_q       <= 1'b0;
                     state_q      <= S_DONE;
                  end else begin
                     lf_q       <= 1'b1;
                     char_out_q <= CHAR_LF;
                  end
               end
`else
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
`endif
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               char_valid_q <= 1'b0;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign map_line   = map_line_q;
   assign mem_addr   = mem_addr_q;
   assign char_out   = char_out_q;
   assign char_valid = char_valid_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: registered mapper/memory models, expected stream built from the line rules.
module tb_line_sequencer;
   localparam int LEN = 64;

   logic        clk, rst_n, start, busy, done, char_valid, char_ready;
   logic [7:0]  line, map_line, char_out;
   logic [19:0] map_ptr;
   logic [9:0]  mem_addr;
   logic [15:0] mem_dout;

   logic [19:0] map_tab [256];
   logic [15:0] mem [1024];
   int checks   = 0;
   int failures = 0;

   line_sequencer #(.LEN_MAX(10'd64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .line(line),
      .busy(busy), .done(done), .map_line(map_line), .map_ptr(map_ptr),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .char_out(char_out),
      .char_valid(char_valid), .char_ready(char_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one-register-deep mapper and character memory
   always @(posedge clk) begin
      map_ptr  <= map_tab[map_line];
      mem_dout <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready always high, 1: toggling, 2: random
   task automatic run_line(input logic [7:0] ln, input int mode, input bit poke, input bit wrap_chk);
      logic [7:0] exp_q [$];
      logic [9:0] hist [$];
      int         cnt, cyc, nacc;
      logic [9:0] base;
      bit         fin, found;
      logic       prev_stall;
      logic [7:0] prev_char;
      cnt  = int'(map_tab[ln][19:10]);
      if (cnt > LEN) cnt = LEN;
      base = map_tab[ln][9:0];
      for (int i = 0; i < cnt; i++) begin
         logic [15:0] w;
         w = mem[base + 10'(i)];
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
      end
`ifdef LINE_SEQ_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
      start = 1'b1;
      line  = ln;
      @(negedge clk);
      start = 1'b0;
      line  = 8'($urandom);
      chk("busy_on_start", 32'(busy), 32'd1);
      chk("map_line", 32'(map_line), 32'(ln));
      fin = 1'b0; prev_stall = 1'b0; prev_char = 8'h00; nacc = 0; cyc = 0;
      while (!fin && cyc < 3000) begin
         case (mode)
            0:       char_ready = 1'b1;
            1:       char_ready = cyc[0];
            default: char_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke && cyc == 20) begin
            start = 1'b1;
            line  = ln + 8'd1;
         end else begin
            start = 1'b0;
         end
         #1;
         if (hist.size() == 0 || hist[$] != mem_addr) hist.push_back(mem_addr);
         if (prev_stall) begin
            chk("stall_valid", 32'(char_valid), 32'd1);
            chk("stall_char", 32'(char_out), 32'(prev_char));
         end
         if (done) begin
            chk("done_busy_low", 32'(busy), 32'd0);
            chk("chars_left", 32'(exp_q.size()), 32'd0);
            fin = 1'b1;
         end else begin
            chk("busy_hold", 32'(busy), 32'd1);
         end
         if (char_valid && char_ready) begin
            if (exp_q.size() == 0) chk("extra_char", 32'(char_out), 32'hFFFF_FFFF);
            else chk("char", 32'(char_out), 32'(exp_q.pop_front()));
            nacc++;
         end
         prev_stall = char_valid && !char_ready;
         prev_char  = char_out;
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk("done_timeout", 32'd0, 32'd1);
      start = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("valid_after_done", 32'(char_valid), 32'd0);
      if (wrap_chk) begin
         found = 1'b0;
         for (int k = 0; k + 1 < hist.size(); k++)
            if (hist[k] == 10'h3FF && hist[k+1] == 10'h000) found = 1'b1;
         chk("addr_wrap_seq", 32'(found), 32'd1);
      end
   endtask

   initial begin
      int nacc, cyc;
      logic [7:0] rl;
      rst_n = 1'b1; start = 1'b0; char_ready = 1'b0; line = 8'h00;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) map_tab[i] = 20'h00000;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(char_valid), 32'd0);
      chk("rst_char", 32'(char_out), 32'h00);
      chk("rst_map_line", 32'(map_line), 32'h00);
      chk("rst_mem_addr", 32'(mem_addr), 32'h000);
      rst_n = 1'b1;
      @(negedge clk);

      mem[0] = 16'h3131; mem[1] = 16'h4142; mem[2] = 16'h7320;
      map_tab[0] = 20'h00C00;
      run_line(8'd0, 0, 1'b0, 1'b0);
      map_tab[5] = 20'h00000;
      run_line(8'd5, 0, 1'b0, 1'b0);
      run_line(8'd0, 1, 1'b0, 1'b0);
      map_tab[7] = {10'd2, 10'h3FF};
      run_line(8'd7, 2, 1'b0, 1'b1);
      map_tab[9]  = {10'h3FF, 10'($urandom)};
      map_tab[10] = {10'd1, 10'h155};
      run_line(8'd9, 2, 1'b1, 1'b0);
      map_tab[11] = {10'd65, 10'($urandom)};
      run_line(8'd11, 0, 1'b0, 1'b0);
      map_tab[12] = {10'd64, 10'h3F0};
      run_line(8'd12, 2, 1'b0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         rl = 8'($urandom_range(20, 200));
         map_tab[rl] = {10'($urandom_range(0, 80)), 10'($urandom)};
         run_line(rl, $urandom_range(0, 2), 1'b0, 1'b0);
      end

      // reset while the third character is on the bus
      start = 1'b1; line = 8'd0;
      @(negedge clk);
      start = 1'b0; char_ready = 1'b1;
      nacc = 0; cyc = 0;
      while (cyc < 200 && !(nacc == 2 && char_valid)) begin
         if (char_valid && char_ready) nacc++;
         @(negedge clk);
         cyc++;
      end
      chk("rst_reach_third", 32'(nacc == 2 && char_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(char_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_char", 32'(char_out), 32'h00);
      chk("midrst_map_line", 32'(map_line), 32'h00);
      chk("midrst_mem_addr", 32'(mem_addr), 32'h000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      map_tab[1] = {10'd5, 10'($urandom)};
      run_line(8'd1, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
